// File: rtl/ad5592r_pkg.sv
// Shared constants and types for the AD5592R SPI responder: command addresses,
// soft-reset key, frame width and the result state encoding.
package ad5592r_pkg;

  localparam int FRAME_W   = 16;
  localparam int NUM_SLOTS = 9;   // ADC channels 0..7 plus the temperature slot
  localparam int TEMP_SLOT = 8;

  localparam logic [3:0] ADDR_SEQ    = 4'h2;
  localparam logic [3:0] ADDR_GPCTRL = 4'h3;
  localparam logic [3:0] ADDR_ADCCFG = 4'h4;
  localparam logic [3:0] ADDR_RESET  = 4'hF;

  localparam logic [10:0] SOFT_RESET_KEY = 11'h5AC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_READY,
    ST_DONE
  } res_state_e;

endpackage

// File: rtl/ad5592r_spi_responder_if.sv
// Serial link of the AD5592R responder: frame select, command data in, result data out.
interface ad5592r_spi_responder_if;

  logic SYNC1;
  logic SDI1;
  logic SDO1;

  modport master (output SYNC1, output SDI1, input SDO1);
  modport slave  (input SYNC1, input SDI1, output SDO1);

endinterface

// File: rtl/ad5592r_seq_pointer.sv
// Combinational search for the next enabled sequence slot; wrap_o reports that no
// higher slot exists and next_o then holds the lowest enabled slot.
module ad5592r_seq_pointer
  import ad5592r_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] en_i,
  input  logic [3:0]           cur_i,
  input  logic                 from_start_i,
  output logic [3:0]           next_o,
  output logic                 any_o,
  output logic                 wrap_o
);

  logic [3:0] first_idx;

  // NOTE: every output gets a default before the search so no path infers a latch.
  always_comb begin
    first_idx = '0;
    next_o    = '0;
    wrap_o    = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (en_i[i]) first_idx = 4'(i);
      if (en_i[i] && (from_start_i || (4'(i) > cur_i))) begin
        next_o = 4'(i);
        wrap_o = 1'b0;
      end
    end
    if (wrap_o) next_o = first_idx;
    any_o = |en_i;
  end

endmodule

// File: rtl/ad5592r_spi_responder.sv
// AD5592R SPI slave stand-in: decodes command frames and streams ADC sequence results.
// Define AD5592R_RESPONDER_TEMP_EN to enable the temperature slot (sequence word bit 8).
module ad5592r_spi_responder
  import ad5592r_pkg::*;
#(
  parameter int          CONV_LATENCY = 9,
  parameter logic [11:0] TEMP_CODE    = 12'h3A0
) (
  input  logic                   SCLK,
  input  logic                   RESET,
  ad5592r_spi_responder_if.slave spi,
  input  logic [95:0]            ADC_SAMPLE_IN,
  output logic [7:0]             CFG_ADC_PINS,
  output logic [7:0]             SEQ_CH,
  output logic                   SEQ_REP,
  output logic [10:0]            GP_CTRL,
  output logic                   DAC_WR_VALID,
  output logic [2:0]             DAC_WR_CH,
  output logic [11:0]            DAC_WR_DATA,
  output logic [7:0]             FRAME_ERR_CNT
);

  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_shift_q, rx_shift_d;
  logic [15:0] tx_shift_q, tx_shift_d;
  res_state_e  state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  lat_q, lat_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [7:0]  seq_ch_q, seq_ch_d;
  logic        seq_rep_q, seq_rep_d;
  logic        seq_temp_q, seq_temp_d;
  logic [10:0] gp_q, gp_d;
  logic        dac_valid_q, dac_valid_d;
  logic [2:0]  dac_ch_q, dac_ch_d;
  logic [11:0] dac_data_q, dac_data_d;
  logic [7:0]  err_q, err_d;

  logic [15:0]          word;
  logic [3:0]           addr;
  logic                 commit, abort, seq_wr, temp_bit;
  logic [NUM_SLOTS-1:0] new_mask, cur_mask;
  logic [3:0]           ptr_next;
  logic                 ptr_any, ptr_wrap;
  logic [15:0]          pending;
  logic [7:0][11:0]     samples;

  assign samples = ADC_SAMPLE_IN;
  assign word    = {rx_shift_q[14:0], spi.SDI1};
  assign addr    = word[14:11];
  assign commit  = !spi.SYNC1 && (bit_cnt_q == 5'(FRAME_W - 1));
  assign abort   = spi.SYNC1 && (bit_cnt_q != '0) && (bit_cnt_q < 5'(FRAME_W));
  assign seq_wr  = commit && !word[15] && (addr == ADDR_SEQ);

`ifdef AD5592R_RESPONDER_TEMP_EN
  assign temp_bit = word[8];
`else
  assign temp_bit = 1'b0;
`endif

  assign new_mask = {temp_bit, word[7:0]};
  assign cur_mask = {seq_temp_q, seq_ch_q};

  // A sequence write searches its new mask from slot 0; otherwise advance past ptr_q.
  ad5592r_seq_pointer u_seq_pointer (
    .en_i         (seq_wr ? new_mask : cur_mask),
    .cur_i        (ptr_q),
    .from_start_i (seq_wr),
    .next_o       (ptr_next),
    .any_o        (ptr_any),
    .wrap_o       (ptr_wrap)
  );

  always_comb begin
    pending = '0;
    if (state_q == ST_READY) begin
      if (ptr_q == 4'(TEMP_SLOT)) pending = {4'b1000, TEMP_CODE};
      else                        pending = {1'b0, ptr_q[2:0], samples[ptr_q[2:0]]};
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    lat_d       = lat_q;
    cfg_d       = cfg_q;
    seq_ch_d    = seq_ch_q;
    seq_rep_d   = seq_rep_q;
    seq_temp_d  = seq_temp_q;
    gp_d        = gp_q;
    dac_valid_d = 1'b0;
    dac_ch_d    = dac_ch_q;
    dac_data_d  = dac_data_q;
    err_d       = err_q;

    if (!spi.SYNC1) begin
      tx_shift_d = {tx_shift_q[14:0], 1'b0};
      if (bit_cnt_q < 5'(FRAME_W)) begin
        rx_shift_d = word;
        bit_cnt_d  = bit_cnt_q + 5'd1;
      end
    end else begin
      tx_shift_d = pending;
      bit_cnt_d  = '0;
      if (abort && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    case (state_q)
      ST_CONVERT: begin
        lat_d = (lat_q == '0) ? '0 : lat_q - 8'd1;
        if (lat_q <= 8'd1) state_d = ST_READY;
      end
      ST_READY: begin
        if (commit) begin
          if (!ptr_wrap || seq_rep_q) ptr_d   = ptr_next;
          else                        state_d = ST_DONE;
        end
      end
      default: ;
    endcase

    // Command decode comes last so a sequence write overrides the advance above.
    if (commit) begin
      if (word[15]) begin
        dac_ch_d    = word[14:12];
        dac_data_d  = word[11:0];
        dac_valid_d = 1'b1;
      end else begin
        case (addr)
          ADDR_ADCCFG: cfg_d = word[7:0];
          ADDR_GPCTRL: gp_d  = word[10:0];
          ADDR_SEQ: begin
            seq_rep_d  = word[9];
            seq_ch_d   = word[7:0];
            seq_temp_d = temp_bit;
            ptr_d      = ptr_next;
            lat_d      = 8'(CONV_LATENCY);
            state_d    = ptr_any ? ST_CONVERT : ST_IDLE;
          end
          ADDR_RESET: begin
            // bit_cnt stays saturated so trailing bits of this frame remain ignored.
            if (word[10:0] == SOFT_RESET_KEY) begin
              rx_shift_d = '0;
              tx_shift_d = '0;
              state_d    = ST_IDLE;
              ptr_d      = '0;
              lat_d      = '0;
              cfg_d      = '0;
              seq_ch_d   = '0;
              seq_rep_d  = 1'b0;
              seq_temp_d = 1'b0;
              gp_d       = '0;
              dac_ch_d   = '0;
              dac_data_d = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lat_q       <= '0;
      cfg_q       <= '0;
      seq_ch_q    <= '0;
      seq_rep_q   <= 1'b0;
      seq_temp_q  <= 1'b0;
      gp_q        <= '0;
      dac_valid_q <= 1'b0;
      dac_ch_q    <= '0;
      dac_data_q  <= '0;
      err_q       <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lat_q       <= lat_d;
      cfg_q       <= cfg_d;
      seq_ch_q    <= seq_ch_d;
      seq_rep_q   <= seq_rep_d;
      seq_temp_q  <= seq_temp_d;
      gp_q        <= gp_d;
      dac_valid_q <= dac_valid_d;
      dac_ch_q    <= dac_ch_d;
      dac_data_q  <= dac_data_d;
      err_q       <= err_d;
    end
  end

  assign spi.SDO1      = tx_shift_q[15];
  assign CFG_ADC_PINS  = cfg_q;
  assign SEQ_CH        = seq_ch_q;
  assign SEQ_REP       = seq_rep_q;
  assign GP_CTRL       = gp_q;
  assign DAC_WR_VALID  = dac_valid_q;
  assign DAC_WR_CH     = dac_ch_q;
  assign DAC_WR_DATA   = dac_data_q;
  assign FRAME_ERR_CNT = err_q;

endmodule

// File: tb/tb_ad5592r_spi_responder.sv
// Self-checking bench for ad5592r_spi_responder: register decode, sequence readback
// through a scoreboard queue, aborts, DAC pulse, soft and hard reset.
module tb_ad5592r_spi_responder;

  localparam int CONV_LATENCY = 9;

  logic        sclk;
  logic        reset;
  logic [95:0] adc_sample;
  logic [7:0]  cfg_adc_pins;
  logic [7:0]  seq_ch;
  logic        seq_rep;
  logic [10:0] gp_ctrl;
  logic        dac_wr_valid;
  logic [2:0]  dac_wr_ch;
  logic [11:0] dac_wr_data;
  logic [7:0]  frame_err_cnt;

  ad5592r_spi_responder_if spi_if ();

  ad5592r_spi_responder #(
    .CONV_LATENCY (CONV_LATENCY),
    .TEMP_CODE    (12'h3A0)
  ) dut (
    .SCLK          (sclk),
    .RESET         (reset),
    .spi           (spi_if),
    .ADC_SAMPLE_IN (adc_sample),
    .CFG_ADC_PINS  (cfg_adc_pins),
    .SEQ_CH        (seq_ch),
    .SEQ_REP       (seq_rep),
    .GP_CTRL       (gp_ctrl),
    .DAC_WR_VALID  (dac_wr_valid),
    .DAC_WR_CH     (dac_wr_ch),
    .DAC_WR_DATA   (dac_wr_data),
    .FRAME_ERR_CNT (frame_err_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sclk);
  endtask

  // Drives one full frame; SDO1 is captured on the same negedges the data is driven.
  task automatic send_frame(input logic [15:0] w, output logic [15:0] rx);
    for (int i = 15; i >= 0; i--) begin
      @(negedge sclk);
      spi_if.SYNC1 = 1'b0;
      spi_if.SDI1  = w[i];
      rx[i]        = spi_if.SDO1;
    end
    @(negedge sclk);
    spi_if.SYNC1 = 1'b1;
  endtask

  task automatic send_partial(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge sclk);
      spi_if.SYNC1 = 1'b0;
      spi_if.SDI1  = w[15-i];
    end
    @(negedge sclk);
    spi_if.SYNC1 = 1'b1;
  endtask

  task automatic write_cmd(input logic [15:0] w);
    logic [15:0] rx;
    send_frame(w, rx);
  endtask

  // Scoreboard: expected result queued with the stimulus, popped when the frame ends.
  task automatic xfer_expect(input logic [15:0] cmd, input logic [15:0] exp, input string tag);
    logic [15:0] rx;
    logic [15:0] e;
    exp_q.push_back(exp);
    send_frame(cmd, rx);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {16'h0, rx}, {16'h0, e});
    end
  endtask

  function automatic logic [15:0] exp_word(input int ch);
    logic [2:0] c;
    c = 3'(ch);
    return {1'b0, c, 12'h100 + {9'b0, c}};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_cfg"},    {24'h0, cfg_adc_pins}, 32'h0);
    check({tag, "_seqch"},  {24'h0, seq_ch}, 32'h0);
    check({tag, "_seqrep"}, {31'h0, seq_rep}, 32'h0);
    check({tag, "_gp"},     {21'h0, gp_ctrl}, 32'h0);
    check({tag, "_dacv"},   {31'h0, dac_wr_valid}, 32'h0);
    check({tag, "_dacch"},  {29'h0, dac_wr_ch}, 32'h0);
    check({tag, "_dacd"},   {20'h0, dac_wr_data}, 32'h0);
    check({tag, "_sdo"},    {31'h0, spi_if.SDO1}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    spi_if.SYNC1 = 1'b1;
    spi_if.SDI1  = 1'b0;
    for (int n = 0; n < 8; n++) adc_sample[12*n +: 12] = 12'h100 + 12'(n);
    idle(3);
    reset = 1'b0;
    idle(1);
    check_all_zero("reset");
    check("reset_err", {24'h0, frame_err_cnt}, 32'h0);

    // Register writes.
    write_cmd(16'h20FF);
    check("cfg_write", {24'h0, cfg_adc_pins}, 32'hFF);
    write_cmd(16'h19A0);
    check("gp_write", {21'h0, gp_ctrl}, 32'h1A0);
    check("err_after_writes", {24'h0, frame_err_cnt}, 32'h0);

    // Repeating sequence over all eight channels.
    write_cmd(16'h12FF);
    check("seq_ch_ff", {24'h0, seq_ch}, 32'hFF);
    check("seq_rep_1", {31'h0, seq_rep}, 32'h1);
    idle(CONV_LATENCY + 3);
    for (int k = 0; k < 9; k++) xfer_expect(16'h0000, exp_word(k % 8), $sformatf("rep_frame%0d", k));

    // Sequence rewrite while a result is in flight: the current result still goes out.
    xfer_expect(16'h1005, exp_word(1), "seq_overlap");
    check("seq_ch_05", {24'h0, seq_ch}, 32'h05);
    check("seq_rep_0", {31'h0, seq_rep}, 32'h0);
    idle(CONV_LATENCY + 3);
    xfer_expect(16'h0000, 16'h0100, "norep_ch0");
    xfer_expect(16'h0000, 16'h2102, "norep_ch2");
    xfer_expect(16'h0000, 16'h0000, "norep_done");

    // Aborted frames.
    send_partial(16'h20AA, 7);
    idle(1);
    check("abort_cfg_kept", {24'h0, cfg_adc_pins}, 32'hFF);
    check("abort_err_1", {24'h0, frame_err_cnt}, 32'h1);
    for (int k = 0; k < 255; k++) send_partial(16'h20AA, 1 + (k % 15));
    idle(1);
    check("abort_err_sat", {24'h0, frame_err_cnt}, 32'hFF);
    send_partial(16'h20AA, 3);
    idle(1);
    check("abort_err_hold", {24'h0, frame_err_cnt}, 32'hFF);

    // DAC write pulse.
    check("dac_valid_idle", {31'h0, dac_wr_valid}, 32'h0);
    write_cmd(16'hB7FF);
    check("dac_valid_hi", {31'h0, dac_wr_valid}, 32'h1);
    check("dac_ch", {29'h0, dac_wr_ch}, 32'h3);
    check("dac_data", {20'h0, dac_wr_data}, 32'h7FF);
    idle(1);
    check("dac_valid_lo", {31'h0, dac_wr_valid}, 32'h0);
    check("dac_ch_hold", {29'h0, dac_wr_ch}, 32'h3);

    // Soft reset keeps only the error counter.
    write_cmd(16'h7DAC);
    idle(1);
    check_all_zero("soft");
    check("soft_err_kept", {24'h0, frame_err_cnt}, 32'hFF);
    xfer_expect(16'h0000, 16'h0000, "soft_sdo_idle");

    // Hard reset in the middle of a frame.
    write_cmd(16'h20FF);
    check("pre_reset_cfg", {24'h0, cfg_adc_pins}, 32'hFF);
    for (int i = 0; i < 9; i++) begin
      @(negedge sclk);
      spi_if.SYNC1 = 1'b0;
      spi_if.SDI1  = 1'b1;
    end
    @(negedge sclk);
    reset = 1'b1;
    @(negedge sclk);
    reset        = 1'b0;
    spi_if.SYNC1 = 1'b1;
    check_all_zero("hard");
    check("hard_err", {24'h0, frame_err_cnt}, 32'h0);
    idle(2);
    write_cmd(16'h19A0);
    check("post_reset_gp", {21'h0, gp_ctrl}, 32'h1A0);
    check("post_reset_err", {24'h0, frame_err_cnt}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad5592r_spi_responder.md
Name: ad5592r_spi_responder

Overview:
- Behavioural-synthesizable SPI slave for the AD5592R protocol. It is the responder end of the mixed-signal chip link.
- Frame handling:
  - Accepts 16-bit command frames on SDI1 while SYNC1 is low.
  - Decodes control-register and DAC writes.
  - Returns ADC sequence results on SDO1 from a parallel sample bus.
- Used on the FPGA side as the stand-in for the ADC chip in loopback and hardware-in-the-loop builds.

Parameters:
- CONV_LATENCY, 9: SCLK cycles after a sequence-register commit before the first result word is available.
- TEMP_CODE, 12'h3A0: fixed temperature result code (optional feature only).

Ports:
- SCLK  input  1  single clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- SYNC1  input  1  frame select, active low.
- SDI1  input  1  serial command data, MSB first.
- ADC_SAMPLE_IN  input  96  eight 12-bit samples; channel n at [12n+11:12n].
- SDO1  output  1  serial result data, MSB first.
- CFG_ADC_PINS  output  8  ADC pin configuration register.
- SEQ_CH  output  8  ADC sequence channel enables.
- SEQ_REP  output  1  sequence repeat bit.
- GP_CTRL  output  11  general-purpose control register bits [10:0].
- DAC_WR_VALID  output  1  one-cycle pulse on DAC write commit.
- DAC_WR_CH  output  3  DAC channel of last write.
- DAC_WR_DATA  output  12  DAC code of last write.
- FRAME_ERR_CNT  output  8  saturating count of aborted frames.

Behaviour:
- Reset:
  - All outputs and registers go to 0; SDO1=0.
  - Bit counter goes to 0; sequence pointer idle; latency counter cleared.
  - Reset mid-frame discards the frame without counting an error.
- Receive:
  - Each posedge with SYNC1=0 shifts SDI1 into rx_shift (LSB-in) and increments bit_cnt (saturates at 16).
  - Commit happens on the edge where bit_cnt becomes 16, using the completed word.
  - Further bits while SYNC1 stays low are ignored.
  - SYNC1 high resets bit_cnt.
- Abort: SYNC1 observed high with 0<bit_cnt<16 → frame discarded, FRAME_ERR_CNT+1 (saturates at 255), no register change.
- Decode of committed word w:
  - w[15]=1: DAC write. DAC_WR_CH=w[14:12], DAC_WR_DATA=w[11:0], DAC_WR_VALID=1 for exactly the following cycle.
  - w[15]=0, w[14:11]=4'b0100: CFG_ADC_PINS=w[7:0].
  - w[15]=0, w[14:11]=4'b0011: GP_CTRL=w[10:0].
  - w[15]=0, w[14:11]=4'b0010: SEQ_REP=w[9], SEQ_CH=w[7:0]. Also restarts the sequence: pointer to lowest enabled channel, latency counter loaded with CONV_LATENCY.
  - w[15]=0, w[14:11]=4'b1111 and w[10:0]=11'h5AC: soft reset, same effect as RESET except FRAME_ERR_CNT is kept.
  - w=16'h0000 (NOP) and all other addresses: no register effect.
- Result state machine:
  - States IDLE, CONVERT, READY, DONE.
  - IDLE → CONVERT on sequence commit with a non-zero enable set. An all-zero enable set goes to IDLE.
  - CONVERT counts down the latency; reaching 0 → READY.
  - In READY, the pending word is {1'b0, ch[2:0], sample_ch[11:0]}. The sample is taken from ADC_SAMPLE_IN on the cycle the word is loaded.
  - After each completed 16-bit frame in READY, the pointer advances to the next higher enabled channel.
  - Past the highest enabled channel: SEQ_REP=1 wraps to the lowest; SEQ_REP=0 → DONE.
  - Aborted frames do not advance the pointer.
- Transmit:
  - While SYNC1=1, tx_shift is loaded every cycle with the pending word (16'h0000 outside READY).
  - SDO1 = tx_shift[15], so bit 15 is valid before the first SYNC1-low edge.
  - Each SYNC1-low posedge shifts left with 0 fill.
- A sequence write committing in the same frame that returns a result still completes that result's transmission. The new sequence then takes effect.

Optional Feature:
- Macro: AD5592R_RESPONDER_TEMP_EN.
- Defined:
  - Sequence word bit 8 enables the temperature slot.
  - The slot is ordered after channel 7 and returns {4'b1000, TEMP_CODE}.
- Undefined: bit 8 is ignored; the temperature slot never occurs.

Decomposition:
- Shared package ad5592r_pkg holds:
  - Address constants ADDR_SEQ=4'h2, ADDR_GPCTRL=4'h3, ADDR_ADCCFG=4'h4, ADDR_RESET=4'hF.
  - SOFT_RESET_KEY=11'h5AC.
  - Result-state enum.
  - Frame width constant 16.
- One sub-module, ad5592r_seq_pointer: combinational next-enabled-channel search with wrap flag, reused by both the commit path and the advance path.

Test Plan:
1. Shift 16'h20FF → CFG_ADC_PINS=8'hFF; shift 16'h19A0 → GP_CTRL=11'h1A0; FRAME_ERR_CNT stays 0.
2. ADC_SAMPLE_IN channel n = 12'h100+n; write 16'h12FF; wait 9 cycles; read 8 frames → SDO words 16'h0100, 16'h1101, …, 16'h7107; 9th frame returns 16'h0100 (REP=1).
3. Write 16'h1005 (REP=0, ch0 and ch2) → frames return 16'h0100, 16'h2102, then 16'h0000.
4. Raise SYNC1 after 7 bits of 16'h20AA → CFG_ADC_PINS unchanged, FRAME_ERR_CNT=1; 256 aborts saturate the count at 255.
5. Shift 16'hB7FF → DAC_WR_VALID pulses 1 cycle, DAC_WR_CH=3, DAC_WR_DATA=12'h7FF; then 16'h7DAC soft reset → all registers 0, FRAME_ERR_CNT kept.
6. Assert RESET at bit 9 of a frame → all outputs 0, FRAME_ERR_CNT=0; next complete frame decodes normally.
